// File: rtl/microsequencer.sv
// Microsequencer: selects the next microstore state from the current microword
// fields, a condition flag and an opcode encoder. It also keeps a one-deep
// return register for CALL/RETURN and a sticky illegal-opcode flag.
module microsequencer (
  input  logic       clk,
  input  logic       reset,        // asynchronous, active-low
  input  logic [5:0] opcode,
  input  logic [2:0] ns_sel,
  input  logic [1:0] cond_sel,
  input  logic       inv,
  input  logic [6:0] cr_addr,
  input  logic       moc,
  input  logic       branch_cond,
  output logic [6:0] currentState,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    NS_DECODE  = 3'b000,
    NS_JUMP    = 3'b001,
    NS_INC     = 3'b010,
    NS_CJUMP   = 3'b011,
    NS_CDECODE = 3'b100,
    NS_WAIT    = 3'b101,
    NS_CALL    = 3'b110,
    NS_RETURN  = 3'b111
  } ns_mode_e;

  logic [6:0] state_q, state_d;
  logic [6:0] ret_q, ret_d;
  logic       illegal_q, illegal_d;

  logic [6:0] enc_state;
  logic       enc_legal;
  logic       cond;
  logic [6:0] state_inc;
  ns_mode_e   mode;

  assign mode      = ns_mode_e'(ns_sel);
  assign state_inc = state_q + 7'd1;  // 7-bit add, 127 wraps to 0

  // Opcode encoder: maps instruction classes to their first execute state.
  always_comb begin
    enc_state = 7'd0;
    enc_legal = 1'b1;
    case (opcode)
      6'b000000: enc_state = 7'd6;
      6'b100000, 6'b100001, 6'b100011,
      6'b100100, 6'b100101: enc_state = 7'd7;
      6'b101000, 6'b101001, 6'b101011: enc_state = 7'd13;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001111: enc_state = 7'd16;
      6'b000010, 6'b000011: enc_state = 7'd11;
      6'b000100, 6'b000101: enc_state = 7'd12;
      default: begin
        enc_state = 7'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Condition select, optionally inverted.
  always_comb begin
    cond = 1'b0;
    case (cond_sel)
      2'b00:   cond = moc;
      2'b01:   cond = branch_cond;
      2'b10:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
    cond = cond ^ inv;
  end

  // Next-state, return-register and illegal-flag computation.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    illegal_d = illegal_q;
    case (mode)
      NS_DECODE: begin
        state_d = enc_state;
        if (!enc_legal) illegal_d = 1'b1;
      end
      NS_JUMP:   state_d = cr_addr;
      NS_INC:    state_d = state_inc;
      NS_CJUMP:  state_d = cond ? cr_addr : state_inc;
      NS_CDECODE: begin
        if (cond) begin
          state_d = cr_addr;
        end else begin
          state_d = enc_state;
          if (!enc_legal) illegal_d = 1'b1;
        end
      end
      NS_WAIT:   state_d = cond ? state_inc : state_q;
      NS_CALL: begin
        state_d = cr_addr;
        ret_d   = state_inc;
      end
      NS_RETURN: state_d = ret_q;
      default:   state_d = state_q;
    endcase
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= 7'd0;
      ret_q     <= 7'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      illegal_q <= illegal_d;
    end
  end

  assign currentState = state_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed testbench for microsequencer with hand-computed expected states.
module tb_microsequencer;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [2:0] ns_sel;
  logic [1:0] cond_sel;
  logic       inv;
  logic [6:0] cr_addr;
  logic       moc;
  logic       branch_cond;
  logic [6:0] currentState;
  logic       illegal_op;

  int n_cmp;
  int n_err;

  microsequencer dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .ns_sel       (ns_sel),
    .cond_sel     (cond_sel),
    .inv          (inv),
    .cr_addr      (cr_addr),
    .moc          (moc),
    .branch_cond  (branch_cond),
    .currentState (currentState),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Force the state register via JUMP.
  task automatic goto(input logic [6:0] s);
    ns_sel  = 3'b001;
    cr_addr = s;
    tick();
    chk("jump", currentState, s);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    opcode = 6'b0; ns_sel = 3'b010; cond_sel = 2'b00; inv = 1'b0;
    cr_addr = 7'd0; moc = 1'b0; branch_cond = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_state", currentState, 7'd0);
    chk("rst_illegal", {6'b0, illegal_op}, 7'd0);
    #1 reset = 1'b1;

    // First edge after release computes from state 0 (INC -> 1)
    tick();
    chk("first_inc", currentState, 7'd1);

    // Reset pulse between edges clears state at once
    goto(7'd5);
    reset = 1'b0;
    #1;
    chk("rst_pulse", currentState, 7'd0);
    reset = 1'b1;

    // Decode
    ns_sel = 3'b000;
    opcode = 6'b100011; tick(); chk("dec_lw", currentState, 7'd7);
    opcode = 6'b000000; tick(); chk("dec_rtype", currentState, 7'd6);
    opcode = 6'b101011; tick(); chk("dec_sw", currentState, 7'd13);
    opcode = 6'b001111; tick(); chk("dec_lui", currentState, 7'd16);
    opcode = 6'b000011; tick(); chk("dec_jal", currentState, 7'd11);
    opcode = 6'b000101; tick(); chk("dec_bne", currentState, 7'd12);
    opcode = 6'b100101; tick(); chk("dec_lhu", currentState, 7'd7);
    chk("no_illegal", {6'b0, illegal_op}, 7'd0);

    // Memory wait
    goto(7'd8);
    ns_sel = 3'b101; cond_sel = 2'b00; inv = 1'b0; moc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_hold", currentState, 7'd8);
    end
    moc = 1'b1;
    tick();
    chk("wait_done", currentState, 7'd9);
    moc = 1'b0;

    // Conditional jump
    goto(7'd12);
    ns_sel = 3'b011; cond_sel = 2'b01; cr_addr = 7'd16; branch_cond = 1'b1;
    tick(); chk("cj_taken", currentState, 7'd16);
    goto(7'd12);
    ns_sel = 3'b011; cr_addr = 7'd16; branch_cond = 1'b0;
    tick(); chk("cj_not", currentState, 7'd13);
    goto(7'd12);
    ns_sel = 3'b011; cr_addr = 7'd16; inv = 1'b1; branch_cond = 1'b0;
    tick(); chk("cj_inv", currentState, 7'd16);
    inv = 1'b0;
    // Constant conditions
    ns_sel = 3'b011; cond_sel = 2'b10; cr_addr = 7'd50;
    tick(); chk("cj_const1", currentState, 7'd50);
    cond_sel = 2'b11;
    tick(); chk("cj_const0", currentState, 7'd51);

    // CDECODE: c=1 takes cr_addr and ignores an unmapped opcode
    ns_sel = 3'b100; cond_sel = 2'b10; cr_addr = 7'd99; opcode = 6'b111111;
    tick(); chk("cdec_taken", currentState, 7'd99);
    chk("cdec_no_ill", {6'b0, illegal_op}, 7'd0);
    // JUMP with unmapped opcode does not set illegal
    ns_sel = 3'b001; cr_addr = 7'd3;
    tick(); chk("jmp_badop", {6'b0, illegal_op}, 7'd0);
    // CDECODE with c=0 uses encoder
    ns_sel = 3'b100; cond_sel = 2'b11; opcode = 6'b101000;
    tick(); chk("cdec_enc", currentState, 7'd13);

    // Call and return
    goto(7'd20);
    ns_sel = 3'b110; cr_addr = 7'd40;
    tick(); chk("call", currentState, 7'd40);
    ns_sel = 3'b111;
    tick(); chk("ret1", currentState, 7'd21);
    tick(); chk("ret2", currentState, 7'd21);

    // Wrap and illegal opcode
    goto(7'd127);
    ns_sel = 3'b010;
    tick(); chk("wrap", currentState, 7'd0);
    ns_sel = 3'b000; opcode = 6'b111111;
    tick(); chk("dec_bad", currentState, 7'd0);
    chk("illegal_set", {6'b0, illegal_op}, 7'd1);
    opcode = 6'b100011;
    tick(); chk("dec_after", currentState, 7'd7);
    chk("illegal_stk", {6'b0, illegal_op}, 7'd1);

    // Reset mid-WAIT
    goto(7'd10);
    ns_sel = 3'b101; cond_sel = 2'b00; inv = 1'b0; moc = 1'b0;
    tick(); chk("wait10", currentState, 7'd10);
    #2 reset = 1'b0;
    #1;
    chk("midrst_state", currentState, 7'd0);
    chk("midrst_ill", {6'b0, illegal_op}, 7'd0);
    reset = 1'b1;
    ns_sel = 3'b111;
    tick(); chk("ret_after_rst", currentState, 7'd0);

    // CDECODE c=0 with unmapped opcode sets illegal
    ns_sel = 3'b100; cond_sel = 2'b11; inv = 1'b0; opcode = 6'b111110;
    tick(); chk("cdec_bad", currentState, 7'd0);
    chk("cdec_ill", {6'b0, illegal_op}, 7'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
